scr1_axi_single_mst: RTL and testbench
======================================

Name: scr1_axi_single_mst

Overview:
Single-outstanding AXI4 initiator that turns a simple valid/ready memory request (read/write, byte/half/word) into single-beat AXI transactions. It is the master counterpart of the team's AXI memory responder and drives its AW/W/B/AR/R channels. It is used as the bridge behind the core's data and instruction ports, and as a bus driver in testbenches.

Parameters:
W_ID, 4, AXI ID width; transaction ID counter width
W_ADR, 32, address width
W_DATA, 32, data width; only 32 supported (4 byte lanes)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1=write, 0=read
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_addr  in  W_ADR  byte address
req_wdata  in  W_DATA  write data, right-aligned (LSBs)
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_rdata  out  W_DATA  read data, right-aligned, zero-extended; 0 for writes/errors
rsp_err  out  1  1=misaligned, illegal size, bus error or protocol error
awvalid, awready  out, in  1  write address handshake
awid, awaddr, awsize  out  W_ID, W_ADR, 3  txn_id, req_addr, req_size
awlen, arlen  out  8  constant 0 (single beat)
wvalid, wready  out, in  1  write data handshake
wdata, wstrb, wlast  out  W_DATA, 4, 1  lane-shifted data, byte strobes, constant 1
bvalid, bready  in, out  1  write response handshake
bid, bresp  in  W_ID, 2  write response ID, status
arvalid, arready  out, in  1  read address handshake
arid, araddr, arsize, arburst  out  W_ID, W_ADR, 3, 2  txn_id, req_addr, req_size, constant 2'b01 (INCR)
rvalid, rready  in, out  1  read data handshake
rid, rdata, rresp, rlast  in  W_ID, W_DATA, 2, 1  read response fields

Behaviour:
- Reset values: req_ready=0 during reset, 1 in the first IDLE cycle after. All *valid/*ready outputs=0, rsp_rdata=0, rsp_err=0, txn_id=0, state=IDLE. All outputs are registered.
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, latch write/size/addr/wdata.
    - Illegal size, or misaligned access (half with addr[0]!=0, word with addr[1:0]!=0): go to RSP with rsp_err=1. No bus activity; txn_id unchanged.
    - Legal read: go to RD_ADDR. Legal write: go to WR_REQ.
  - RD_ADDR: arvalid=1, held stable until arready. After the handshake go to RD_DATA.
  - RD_DATA: rready=1. On rvalid:
    - rsp_rdata = (rdata >> 8*addr[1:0]), masked to size.
    - rsp_err = (rresp!=0) | !rlast.
    - Go to RSP.
  - WR_REQ: awvalid and wvalid both asserted in the same cycle. Each deasserts independently after its own handshake; either order or the same cycle is legal. wdata = req_wdata << 8*addr[1:0]. wstrb = (1,3,F for size 0,1,2) << addr[1:0]. Go to WR_RESP in the cycle after both handshakes have completed.
  - WR_RESP: bready=1. On bvalid: rsp_err=(bresp!=0), go to RSP.
  - RSP: rsp_valid=1 until rsp_ready. Then return to IDLE; req_ready is back at 1 the following cycle.
- txn_id increments (mod 2^W_ID, 2^W_ID-1 wraps to 0) on each AR or AW handshake.
- Latency with a zero-wait responder: accept at cycle 0, arvalid at 1, rvalid at 2, rsp_valid at 3. Writes have the same timing.
- No back-to-back overlap. The next request is accepted only after the response handshake.
- rst asserted mid-transaction: the next cycle is IDLE with reset values and the in-flight transaction is abandoned. The bench must also reset the responder.

Optional Feature:
- SCR1_AXI_MST_ID_CHECK_EN defined: rid/bid are compared to the latched txn_id. A mismatch sets rsp_err=1 and the response is still consumed.
- Undefined: rid/bid are ignored.

Test Plan:
- Word read at 0x100 holding 0xDEADBEEF, responder zero-wait -> arsize=2, arlen=0, rsp_rdata=0xDEADBEEF, rsp_err=0 at cycle 3.
- Byte write 0xA5 to 0x103 -> wstrb=4'b1000, wdata[31:24]=0xA5. A following byte read at 0x103 returns 0x000000A5.
- Half read at 0x101 -> rsp_err=1 one cycle after accept, no arvalid ever asserted.
- awready delayed 3 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid is held 4 cycles, a single bready handshake, rsp_err=0.
- Read returning rresp=2'b10 with rready held and rsp_ready held low for 5 cycles -> rsp_valid stays high with rsp_err=1 until rsp_ready; txn_id reaches 1.
- 17 reads with W_ID=4 -> arid sequence 0..15, then 0. With SCR1_AXI_MST_ID_CHECK_EN, forcing rid=5 when arid=3 gives rsp_err=1.

Source files
------------

// File: rtl/scr1_axi_single_mst.sv
// Single-outstanding AXI4 initiator: one simple request becomes one single-beat AXI transaction.
// Define SCR1_AXI_MST_ID_CHECK_EN to flag rid/bid values that differ from the issued ID.
module scr1_axi_single_mst #(
    parameter int W_ID   = 4,
    parameter int W_ADR  = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [W_ADR-1:0]  req_addr,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              awvalid,
    input  logic              awready,
    output logic [W_ID-1:0]   awid,
    output logic [W_ADR-1:0]  awaddr,
    output logic [2:0]        awsize,
    output logic [7:0]        awlen,
    output logic              wvalid,
    input  logic              wready,
    output logic [W_DATA-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [W_ID-1:0]   bid,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [W_ID-1:0]   arid,
    output logic [W_ADR-1:0]  araddr,
    output logic [2:0]        arsize,
    output logic [7:0]        arlen,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [W_ID-1:0]   rid,
    input  logic [W_DATA-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP
    } state_t;

    state_t            state;
    logic [W_ID-1:0]   txn_id;
    logic [W_ID-1:0]   cur_id;
    logic [1:0]        size_q;
    logic [W_ADR-1:0]  addr_q;

    logic              bad_req;
    logic [3:0]        strb_base;
    logic [W_DATA-1:0] rd_mask;
    logic [W_DATA-1:0] rd_shift;
    logic              rid_err;
    logic              bid_err;

    assign awid    = txn_id;
    assign arid    = txn_id;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign arsize  = {1'b0, size_q};
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign wlast   = 1'b1;
    assign arburst = 2'b01;

`ifdef SCR1_AXI_MST_ID_CHECK_EN
    assign rid_err = (rid != cur_id);
    assign bid_err = (bid != cur_id);
`else
    logic unused_id;
    assign unused_id = ^{rid, bid, cur_id};
    assign rid_err   = 1'b0;
    assign bid_err   = 1'b0;
`endif

    always_comb begin
        bad_req   = 1'b0;
        strb_base = 4'hF;
        unique case (req_size)
            2'd0: strb_base = 4'h1;
            2'd1: begin
                strb_base = 4'h3;
                bad_req   = req_addr[0];
            end
            2'd2: bad_req = |req_addr[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    // Read data arrives lane-aligned; move it down to bit 0 and trim to size.
    always_comb begin
        rd_shift = rdata >> {addr_q[1:0], 3'b000};
        rd_mask  = '1;
        unique case (size_q)
            2'd0: rd_mask = W_DATA'(32'h0000_00FF);
            2'd1: rd_mask = W_DATA'(32'h0000_FFFF);
            default: rd_mask = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            txn_id    <= '0;
            cur_id    <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        cur_id    <= txn_id;
                        wdata     <= req_wdata << {req_addr[1:0], 3'b000};
                        wstrb     <= strb_base << req_addr[1:0];
                        if (bad_req) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_write) begin
                            state   <= WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        txn_id  <= txn_id + 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                        if ((rresp != 2'b00) || !rlast || rid_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            rsp_err   <= 1'b0;
                            rsp_rdata <= rd_shift & rd_mask;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        txn_id  <= txn_id + 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    // AW and W complete independently; leave once both are done.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= (bresp != 2'b00) || bid_err;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_axi_single_mst.sv
// Scoreboard bench for scr1_axi_single_mst with a small AXI memory responder.
// Directed requests push expected responses; a monitor checks each response handshake.
module tb_scr1_axi_single_mst;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    scr1_axi_single_mst #(.W_ID(4), .W_ADR(32), .W_DATA(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .awaddr(awaddr), .awsize(awsize), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .araddr(araddr), .arsize(arsize), .arlen(arlen),
        .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder controls
    logic [1:0] rresp_force;
    logic       rid_force;

    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    logic        aw_got;
    logic        w_got;
    logic [31:0] wa_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    logic [3:0]  wid_q;

    wire         aw_hs = awvalid && awready;
    wire         w_hs  = wvalid && wready;
    wire         ag    = aw_got || aw_hs;
    wire         wg    = w_got || w_hs;
    wire [31:0]  wa_n  = aw_hs ? awaddr : wa_q;
    wire [3:0]   wid_n = aw_hs ? awid : wid_q;
    wire [31:0]  wd_n  = w_hs ? wdata : wd_q;
    wire [3:0]   ws_n  = w_hs ? wstrb : ws_q;

    always @(posedge clk) begin
        if (!mem_init) begin
            mem[64]  <= 32'hDEAD_BEEF;
            mem_init <= 1'b1;
        end
        if (rst) begin
            rvalid <= 1'b0;
            bvalid <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            rresp  <= '0;
            rlast  <= 1'b0;
            bid    <= '0;
            bresp  <= '0;
        end else begin
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[9:2]];
                rresp  <= rresp_force;
                rlast  <= 1'b1;
                rid    <= (rid_force && arid == 4'd3) ? 4'd5 : arid;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ag && wg) begin
                for (int b = 0; b < 4; b++)
                    if (ws_n[b]) mem[wa_n[9:2]][8*b +: 8] <= wd_n[8*b +: 8];
                bvalid <= 1'b1;
                bid    <= wid_n;
                bresp  <= 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= ag;
                w_got  <= wg;
                wa_q   <= wa_n;
                wid_q  <= wid_n;
                wd_q   <= wd_n;
                ws_q   <= ws_n;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int ar_cyc = 0;
    int aw_cyc = 0;
    int w_cyc  = 0;
    int b_hs   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid) ar_cyc++;
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if (bvalid && bready) b_hs++;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected none",
                             rsp_rdata, rsp_err);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, x.d);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
                end
            end
        end
    end

    // Returns one cycle after the accepting edge (+1 time unit).
    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic ee);
        exp_t x;
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        x.d = ed;
        x.e = ee;
        sb.push_back(x);
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    int ar0;
    int aw0;
    int w0;
    int b0;
    logic idc;

    initial begin
`ifdef SCR1_AXI_MST_ID_CHECK_EN
        idc = 1'b1;
`else
        idc = 1'b0;
`endif
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b1;
        awready     = 1'b1;
        wready      = 1'b1;
        arready     = 1'b1;
        rresp_force = 2'b00;
        rid_force   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_valids", {28'd0, arvalid, awvalid, wvalid, bready}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Word read, zero-wait latency
        issue(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("rd_arvalid_c1", {31'd0, arvalid}, 32'd1);
        chk("rd_arsize", {29'd0, arsize}, 32'd2);
        chk("rd_arlen", {24'd0, arlen}, 32'd0);
        chk("rd_araddr", araddr, 32'h100);
        chk("rd_arburst", {30'd0, arburst}, 32'd1);
        chk("rd_arid0", {28'd0, arid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rd_rsp_c2", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rd_rsp_c3", {31'd0, rsp_valid}, 32'd1);
        wait_done();

        // Byte write into lane 3, then read it back
        issue(1'b1, 2'd0, 32'h103, 32'h0000_00A5, 32'h0, 1'b0);
        chk("bw_wstrb", {28'd0, wstrb}, 32'h8);
        chk("bw_wdata_hi", {24'd0, wdata[31:24]}, 32'hA5);
        chk("bw_awid", {28'd0, awid}, 32'd1);
        chk("bw_wlast", {31'd0, wlast}, 32'd1);
        wait_done();
        issue(1'b0, 2'd0, 32'h103, 32'h0, 32'h0000_00A5, 1'b0);
        wait_done();
        issue(1'b0, 2'd1, 32'h102, 32'h0, 32'h0000_A5AD, 1'b0);
        wait_done();

        // Misaligned half and illegal size: error with no bus traffic
        ar0 = ar_cyc;
        aw0 = aw_cyc;
        issue(1'b0, 2'd1, 32'h101, 32'h0, 32'h0, 1'b1);
        chk("mis_rsp_c1", {30'd0, rsp_valid, rsp_err}, 32'd3);
        wait_done();
        issue(1'b1, 2'd3, 32'h100, 32'h1234, 32'h0, 1'b1);
        wait_done();
        issue(1'b1, 2'd2, 32'h102, 32'h1234, 32'h0, 1'b1);
        wait_done();
        chk("mis_no_ar", ar_cyc - ar0, 32'd0);
        chk("mis_no_aw", aw_cyc - aw0, 32'd0);

        // awready late by 3 cycles, wready immediate
        aw0 = aw_cyc;
        w0  = w_cyc;
        b0  = b_hs;
        awready = 1'b0;
        issue(1'b1, 2'd2, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        chk("dw_wdata", wdata, 32'h1122_3344);
        chk("dw_wstrb", {28'd0, wstrb}, 32'hF);
        repeat (3) @(posedge clk);
        #1;
        awready = 1'b1;
        wait_done();
        chk("dw_aw_cycles", aw_cyc - aw0, 32'd4);
        chk("dw_w_cycles", w_cyc - w0, 32'd1);
        chk("dw_b_hs", b_hs - b0, 32'd1);
        issue(1'b1, 2'd1, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0);
        chk("hw_wstrb", {28'd0, wstrb}, 32'hC);
        chk("hw_wdata", wdata, 32'hBEEF_0000);
        wait_done();
        issue(1'b0, 2'd2, 32'h20, 32'h0, 32'hBEEF_3344, 1'b0);
        wait_done();

        // Reset in the middle of a stalled read
        arready = 1'b0;
        issue(1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_arvalid_hold", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        pulse_reset();
        chk("mid_rst_clear", {29'd0, arvalid, req_ready, rsp_valid}, 32'd0);

        // Error response held against a stalled consumer
        rresp_force = 2'b10;
        rsp_ready   = 1'b0;
        issue(1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1);
        chk("err_arid", {28'd0, arid}, 32'd0);
        for (int n = 0; n < 20 && !rsp_valid; n++) begin
            @(posedge clk);
            #1;
        end
        for (int n = 0; n < 5; n++) begin
            chk("err_hold", {30'd0, rsp_valid, rsp_err}, 32'd3);
            @(posedge clk);
            #1;
        end
        rresp_force = 2'b00;
        rsp_ready   = 1'b1;
        wait_done();
        issue(1'b0, 2'd2, 32'h100, 32'h0, 32'hA5AD_BEEF, 1'b0);
        chk("err_next_arid", {28'd0, arid}, 32'd1);
        wait_done();

        // ID wrap over 17 reads; rid forced wrong on ID 3
        pulse_reset();
        rid_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            logic e;
            e = idc && (i == 3);
            issue(1'b0, 2'd2, 32'h100, 32'h0,
                  e ? 32'h0 : 32'hA5AD_BEEF, e);
            chk($sformatf("wrap_arid_%0d", i), {28'd0, arid}, 32'(i % 16));
            wait_done();
        end
        rid_force = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
